// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first.
// A registered borrow links consecutive bit slices; results land in output registers on entry to DONE.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
);

   // Counter is at least one bit wide so WIDTH=1 builds cleanly.
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;

   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic [WIDTH-1:0] res_next;
   logic [CW-1:0]    cnt;
   logic             bor;
   logic             bor_next;
   logic             a_bit;
   logic             b_bit;
   logic             d_bit;
   logic             last_bit;

   // Full-subtractor cell on the current LSBs; the new bit enters the result MSB.
   always_comb begin
      a_bit    = a_sr[0];
      b_bit    = b_sr[0];
      d_bit    = a_bit ^ b_bit ^ bor;
      bor_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bor);
      res_next = (res_sr >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
      last_bit = (cnt == LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last_bit) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   // Outputs change only on the final RUN edge, so partial results never show.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         cnt    <= '0;
         bor    <= 1'b0;
         diff   <= '0;
         borrow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr   <= a;
                  b_sr   <= b;
                  res_sr <= '0;
                  cnt    <= '0;
                  bor    <= 1'b0;
               end
            end
            RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= res_next;
               bor    <= bor_next;
               cnt    <= cnt + CW'(1);
               if (last_bit) begin
                  diff   <= res_next;
                  borrow <= bor_next;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, random ops against an arithmetic
// model, back-to-back starts, start-while-busy, mid-run reset and a WIDTH=1 instance.
module tb_serial_subtractor;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       busy;
   logic       done;
   logic [7:0] diff;
   logic       borrow;

   logic       start1;
   logic [0:0] a1;
   logic [0:0] b1;
   logic       busy1;
   logic       done1;
   logic [0:0] diff1;
   logic       borrow1;

   int tests_run;
   int tests_failed;

   logic [7:0] last_diff;
   logic       last_bor;
   logic [15:0] exp_q[$];

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] d;
      logic       bor;
   } vec_t;

   vec_t vecs[6];
   vec_t vecs1[4];

   serial_subtractor #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .diff(diff), .borrow(borrow)
   );

   serial_subtractor #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One WIDTH=8 operation; optionally pulses start with a=1,b=1 at RUN cycle inject_at.
   task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input int inject_at);
      logic [7:0] ed;
      logic       eb;
      int         done_cyc;
      int         busy_cyc;
      bit         held;
      ed = 8'((32'(av) - 32'(bv)) & 32'hff);
      eb = (av < bv);
      @(negedge clk);
      start = 1'b1; a = av; b = bv;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; a = 8'($urandom); b = 8'($urandom);
      done_cyc = 0; busy_cyc = 0; held = 1'b1;
      for (int cyc = 1; cyc <= 20 && done_cyc == 0; cyc++) begin
         if (cyc > 1) @(negedge clk);
         if (busy) busy_cyc++;
         if (done) done_cyc = cyc;
         else if (diff !== last_diff || borrow !== last_bor) held = 1'b0;
         if (cyc == inject_at) begin
            start = 1'b1; a = 8'd1; b = 8'd1;
         end else if (cyc == inject_at + 1) begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      chk("done_latency", done_cyc, 9);
      chk("busy_cycles", busy_cyc, 9);
      chk("diff", diff, ed);
      chk("borrow", borrow, eb);
      chk("hold_until_done", held, 1);
      @(negedge clk);
      chk("idle_after_done", {busy, done}, 0);
      last_diff = ed;
      last_bor  = eb;
   endtask

   task automatic op1(input logic av, input logic bv, input logic ed, input logic eb);
      int done_cyc;
      @(negedge clk);
      start1 = 1'b1; a1 = av; b1 = bv;
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0; a1 = ~av; b1 = ~bv;
      done_cyc = 0;
      for (int cyc = 1; cyc <= 10 && done_cyc == 0; cyc++) begin
         if (cyc > 1) @(negedge clk);
         if (done1) done_cyc = cyc;
      end
      chk("w1_done_latency", done_cyc, 2);
      chk("w1_diff", diff1, ed);
      chk("w1_borrow", borrow1, eb);
      @(negedge clk);
      chk("w1_idle_after_done", {busy1, done1}, 0);
   endtask

   initial begin
      int spurious;
      logic [15:0] ops;
      logic [7:0]  ra;
      logic [7:0]  rb;

      tests_run = 0; tests_failed = 0;
      last_diff = '0; last_bor = 1'b0;
      start = 1'b0; a = '0; b = '0;
      start1 = 1'b0; a1 = '0; b1 = '0;

      vecs[0] = '{8'd200, 8'd55,  8'd145, 1'b0};
      vecs[1] = '{8'd5,   8'd9,   8'd252, 1'b1};
      vecs[2] = '{8'd0,   8'd0,   8'd0,   1'b0};
      vecs[3] = '{8'd255, 8'd255, 8'd0,   1'b0};
      vecs[4] = '{8'd0,   8'd1,   8'd255, 1'b1};
      vecs[5] = '{8'd1,   8'd0,   8'd1,   1'b0};

      vecs1[0] = '{8'd0, 8'd0, 8'd0, 1'b0};
      vecs1[1] = '{8'd0, 8'd1, 8'd1, 1'b1};
      vecs1[2] = '{8'd1, 8'd0, 8'd1, 1'b0};
      vecs1[3] = '{8'd1, 8'd1, 8'd0, 1'b0};

      // Reset
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_diff", diff, 0);
      chk("reset_borrow", borrow, 0);
      chk("reset_w1_outputs", {busy1, done1, diff1, borrow1}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Table vectors, expected values written out by hand
      for (int i = 0; i < 6; i++) begin
         do_op(vecs[i].a, vecs[i].b, 100);
         chk("table_diff", diff, vecs[i].d);
         chk("table_borrow", borrow, vecs[i].bor);
      end

      // Random operations against the arithmetic model inside do_op
      for (int i = 0; i < 20; i++) begin
         do_op(8'($urandom), 8'($urandom), 100);
      end

      // start held high, fresh operands every cycle: only accept-edge operands count
      for (int j = 0; j < 50; j++) begin
         ra = 8'($urandom); rb = 8'($urandom);
         start = 1'b1; a = ra; b = rb;
         if (j % 10 == 0) exp_q.push_back({ra, rb});
         @(posedge clk);
         @(negedge clk);
         chk("stream_done", done, (j % 10 == 8) ? 1 : 0);
         if (done) begin
            if (exp_q.size() > 0) begin
               ops = exp_q.pop_front();
               last_diff = 8'((32'(ops[15:8]) - 32'(ops[7:0])) & 32'hff);
               last_bor  = (ops[15:8] < ops[7:0]);
               chk("stream_diff", diff, last_diff);
               chk("stream_borrow", borrow, last_bor);
            end else begin
               chk("stream_queue_nonempty", 0, 1);
            end
         end
      end
      start = 1'b0;
      chk("stream_queue_drained", exp_q.size(), 0);
      @(negedge clk);

      // start pulsed mid-RUN is ignored
      do_op(8'd37, 8'd90, 3);
      chk("ignored_start_diff", diff, 8'd203);
      chk("ignored_start_borrow", borrow, 1);

      // Asynchronous reset at RUN cycle 4
      @(negedge clk);
      start = 1'b1; a = 8'd200; b = 8'd3;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("async_reset_busy", busy, 0);
      chk("async_reset_done", done, 0);
      chk("async_reset_diff", diff, 0);
      chk("async_reset_borrow", borrow, 0);
      @(negedge clk);
      rst_n = 1'b1;
      last_diff = '0; last_bor = 1'b0;
      spurious = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done || busy) spurious++;
      end
      chk("no_activity_after_reset", spurious, 0);
      do_op(8'd100, 8'd1, 100);
      chk("after_reset_diff", diff, 8'd99);

      // WIDTH=1 instance
      for (int i = 0; i < 4; i++) begin
         op1(vecs1[i].a[0], vecs1[i].b[0], vecs1[i].d[0], vecs1[i].bor);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
